// File: rtl/activation_control_if.sv
// Instruction, accumulator-read, activation-control and buffer-write signals of the activation sequencer.
// Function fields carry activation_control_pkg::activation_type encodings (0 none, 1 relu, 2 sigmoid).
interface activation_control_if #(
    parameter int ACC_ADDR_WIDTH = 9,
    parameter int BUF_ADDR_WIDTH = 24,
    parameter int LENGTH_WIDTH   = 16
);
    logic                      instr_valid;
    logic                      instr_ready;
    logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr;
    logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr;
    logic [LENGTH_WIDTH-1:0]   instr_length;
    logic [1:0]                instr_function;
    logic                      instr_signed;
    logic                      acc_rd_en;
    logic [ACC_ADDR_WIDTH-1:0] acc_rd_addr;
    logic                      act_enable;
    logic [1:0]                act_function;
    logic                      act_signed;
    logic                      buf_wr_en;
    logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr;
    logic                      busy;
    logic                      done;

    modport master (
        input  instr_valid, instr_acc_addr, instr_buf_addr, instr_length, instr_function, instr_signed,
        output instr_ready, acc_rd_en, acc_rd_addr, act_enable, act_function, act_signed,
               buf_wr_en, buf_wr_addr, busy, done
    );

    modport slave (
        output instr_valid, instr_acc_addr, instr_buf_addr, instr_length, instr_function, instr_signed,
        input  instr_ready, acc_rd_en, acc_rd_addr, act_enable, act_function, act_signed,
               buf_wr_en, buf_wr_addr, busy, done
    );
endinterface

// File: rtl/activation_control.sv
// Activation unit sequencer: streams LENGTH accumulator rows through the activation pipeline into the
// unified buffer, aligning read strobes, function/sign and write strobes.
package activation_control_pkg;
    typedef enum logic [1:0] {
        NO_ACTIVATION = 2'd0,
        RELU          = 2'd1,
        SIGMOID       = 2'd2
    } activation_type;
endpackage

module activation_control
    import activation_control_pkg::*;
#(
    parameter int ACC_ADDR_WIDTH   = 9,
    parameter int BUF_ADDR_WIDTH   = 24,
    parameter int LENGTH_WIDTH     = 16,
    parameter int ACC_READ_LATENCY = 2,
    parameter int ACT_LATENCY      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    activation_control_if.master bus
);
    localparam int L = ACC_READ_LATENCY + ACT_LATENCY;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [ACC_ADDR_WIDTH-1:0] rd_addr;
    logic [BUF_ADDR_WIDTH-1:0] wr_addr;
    logic [LENGTH_WIDTH-1:0]   rd_cnt, wr_cnt;
    activation_type            fn_q;
    logic                      sgn_q;
    logic [L-1:0]              vld_p;
    activation_type            fn_dly [ACC_READ_LATENCY];
    logic [ACC_READ_LATENCY-1:0] sgn_dly;
    logic                      done_q;
    logic                      accept, rd_en, wr_en, last_rd, last_wr, act_vld;

    assign accept  = bus.instr_valid && (state == IDLE);
    assign rd_en   = (state == READ);
    assign wr_en   = vld_p[L-1];
    assign last_rd = rd_en && (rd_cnt == LENGTH_WIDTH'(1));
    assign last_wr = wr_en && (wr_cnt == LENGTH_WIDTH'(1));
    // Read data reaches the activation input ACC_READ_LATENCY cycles after its strobe.
    assign act_vld = vld_p[ACC_READ_LATENCY-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (bus.instr_length != '0)) state_nxt = READ;
            READ:    if (last_rd) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_addr <= '0;
            wr_addr <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            fn_q    <= NO_ACTIVATION;
            sgn_q   <= 1'b0;
            vld_p   <= '0;
            sgn_dly <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < ACC_READ_LATENCY; k++) fn_dly[k] <= NO_ACTIVATION;
        end else begin
            state  <= state_nxt;
            done_q <= (accept && (bus.instr_length == '0)) || last_wr;
            if (accept) begin
                rd_addr <= bus.instr_acc_addr;
                wr_addr <= bus.instr_buf_addr;
                rd_cnt  <= bus.instr_length;
                wr_cnt  <= bus.instr_length;
                fn_q    <= activation_type'(bus.instr_function);
                sgn_q   <= bus.instr_signed;
            end else begin
                if (rd_en) begin
                    rd_addr <= rd_addr + ACC_ADDR_WIDTH'(1);
                    rd_cnt  <= rd_cnt - LENGTH_WIDTH'(1);
                end
                if (wr_en) begin
                    wr_addr <= wr_addr + BUF_ADDR_WIDTH'(1);
                    wr_cnt  <= wr_cnt - LENGTH_WIDTH'(1);
                end
            end
            // Per-row valid and function/sign delay lines
            vld_p[0]   <= rd_en;
            fn_dly[0]  <= fn_q;
            sgn_dly[0] <= sgn_q;
            for (int k = 1; k < L; k++) vld_p[k] <= vld_p[k-1];
            for (int k = 1; k < ACC_READ_LATENCY; k++) begin
                fn_dly[k]  <= fn_dly[k-1];
                sgn_dly[k] <= sgn_dly[k-1];
            end
        end
    end

    assign bus.instr_ready  = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.act_enable   = (state != IDLE);
    assign bus.acc_rd_en    = rd_en;
    assign bus.acc_rd_addr  = rd_addr;
    assign bus.act_function = act_vld ? fn_dly[ACC_READ_LATENCY-1] : NO_ACTIVATION;
    assign bus.act_signed   = act_vld && sgn_dly[ACC_READ_LATENCY-1];
    assign bus.buf_wr_en    = wr_en;
    assign bus.buf_wr_addr  = wr_addr;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_activation_control.sv
// Directed bench for activation_control: table of instructions checked cycle by cycle against the
// expected read/activation/write/done timeline, plus reset-mid-read and back-to-back sequences.
module tb_activation_control;
    import activation_control_pkg::*;

    localparam int ACC_W = 9;
    localparam int BUF_W = 24;
    localparam int LEN_W = 16;
    localparam int ARL   = 2;
    localparam int ACTL  = 3;
    localparam int L     = ARL + ACTL;

    typedef struct {
        string          name;
        logic [ACC_W-1:0] acc;
        logic [BUF_W-1:0] bufa;
        int             len;
        activation_type fn;
        bit             sgn;
        int             exp_last_rd;
        int             exp_last_wr;
        int             exp_done_k;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   seen_rd, seen_wr, seen_done;

    activation_control_if #(.ACC_ADDR_WIDTH(ACC_W), .BUF_ADDR_WIDTH(BUF_W), .LENGTH_WIDTH(LEN_W)) bus ();

    activation_control #(
        .ACC_ADDR_WIDTH(ACC_W), .BUF_ADDR_WIDTH(BUF_W), .LENGTH_WIDTH(LEN_W),
        .ACC_READ_LATENCY(ARL), .ACT_LATENCY(ACTL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {ready, busy, act_enable, rd_en, rd_addr, act_function, act_signed, wr_en, wr_addr, done}
    function automatic logic [41:0] obs();
        logic [ACC_W-1:0] ra;
        logic [BUF_W-1:0] wa;
        ra = bus.acc_rd_en ? bus.acc_rd_addr : '0;
        wa = bus.buf_wr_en ? bus.buf_wr_addr : '0;
        return {bus.instr_ready, bus.busy, bus.act_enable, bus.acc_rd_en, ra, bus.act_function,
                bus.act_signed, bus.buf_wr_en, wa, bus.done};
    endfunction

    // Expected outputs k cycles after the accepting edge (k <= 0 means idle)
    function automatic logic [41:0] exp_vec(vec_t r, int k);
        int n;
        bit busy, rd, av, wr, dn;
        logic [ACC_W-1:0] ra;
        logic [BUF_W-1:0] wa;
        logic [1:0] f;
        n    = r.len;
        busy = (n > 0) && (k >= 1) && (k <= n + L);
        rd   = (k >= 1) && (k <= n);
        av   = (k >= 1 + ARL) && (k <= n + ARL);
        wr   = (k >= 1 + L) && (k <= n + L);
        dn   = (n == 0) ? (k == 1) : (k == n + L + 1);
        ra   = rd ? r.acc + ACC_W'(k - 1) : '0;
        wa   = wr ? r.bufa + BUF_W'(k - 1 - L) : '0;
        f    = av ? r.fn : NO_ACTIVATION;
        return {!busy, busy, busy, rd, ra, f, av && r.sgn, wr, wa, dn};
    endfunction

    task automatic chk(string name, logic [41:0] act, logic [41:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t r);
        bus.instr_acc_addr = r.acc;
        bus.instr_buf_addr = r.bufa;
        bus.instr_length   = LEN_W'(r.len);
        bus.instr_function = r.fn;
        bus.instr_signed   = r.sgn;
    endtask

    task automatic apply(vec_t r);
        drive(r);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic span(vec_t r, int k0, int k1);
        for (int k = k0; k <= k1; k++) begin
            chk($sformatf("%s k=%0d", r.name, k), obs(), exp_vec(r, k));
            if (bus.acc_rd_en) seen_rd = int'(bus.acc_rd_addr);
            if (bus.buf_wr_en) seen_wr = int'(bus.buf_wr_addr);
            if (bus.done && seen_done < 0) seen_done = k;
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_seen();
        seen_rd = -1;
        seen_wr = -1;
        seen_done = -1;
    endtask

    task automatic chk_seen(vec_t r);
        chk({r.name, " last_rd"}, 42'(seen_rd), 42'(r.exp_last_rd));
        chk({r.name, " last_wr"}, 42'(seen_wr), 42'(r.exp_last_wr));
        chk({r.name, " done_k"}, 42'(seen_done), 42'(r.exp_done_k));
    endtask

    initial begin
        vec_t tbl[5];
        vec_t idle, a, b, rm;
        tbl[0] = '{"relu_ex", 9'd10, 24'd100, 4, RELU, 1'b1, 13, 103, 10};
        tbl[1] = '{"wrap", 9'd510, 24'd16777214, 4, SIGMOID, 1'b1, 1, 1, 10};
        tbl[2] = '{"len0", 9'd5, 24'd7, 0, RELU, 1'b1, -1, -1, 1};
        tbl[3] = '{"unsigned_n1", 9'd33, 24'd44, 1, NO_ACTIVATION, 1'b0, 33, 44, 7};
        tbl[4] = '{"sigmoid_n7", 9'd200, 24'd1000, 7, SIGMOID, 1'b0, 206, 1006, 13};
        idle   = '{"idle", 9'd0, 24'd0, 0, NO_ACTIVATION, 1'b0, -1, -1, -1};
        a      = '{"b2b_a", 9'd20, 24'd200, 3, RELU, 1'b1, 22, 202, 9};
        b      = '{"b2b_b", 9'd40, 24'd400, 2, SIGMOID, 1'b0, 41, 401, 8};
        rm     = '{"rst_mid", 9'd50, 24'd500, 8, RELU, 1'b1, -1, -1, -1};

        bus.instr_valid = 1'b0;
        drive(idle);
        #1;
        chk("reset_state", obs(), exp_vec(idle, 0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", obs(), exp_vec(idle, 0));

        for (int i = 0; i < 5; i++) begin
            clear_seen();
            apply(tbl[i]);
            span(tbl[i], 1, tbl[i].len + L + 2);
            chk_seen(tbl[i]);
        end

        // Held instr_valid: second instruction accepted only on the first instruction's done cycle
        clear_seen();
        drive(a);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        drive(b);
        span(a, 1, a.len + L + 1);
        chk_seen(a);
        bus.instr_valid = 1'b0;
        clear_seen();
        span(b, 1, b.len + L + 2);
        chk_seen(b);

        // Asynchronous reset while reading: everything drops at once, nothing is written afterwards
        clear_seen();
        apply(rm);
        span(rm, 1, 3);
        rst = 1'b0;
        #1;
        chk("rst_mid_async", obs(), exp_vec(idle, 0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("rst_mid_after c=%0d", k), obs(), exp_vec(idle, 0));
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
